// File: rtl/gb_mbc1.sv
// gb_mbc1: Game Boy MBC1 bank controller. Decodes CPU bus cycles, holds the
// MBC1 bank registers and drives registered ROM / external RAM addresses so
// the downstream single-cycle SPRAMs see a stable address for the whole read.
module gb_mbc1 #(
  parameter int ROM_BANK_BITS = 2,  // 1..7 physical ROM bank bits
  parameter int RAM_BANK_BITS = 0   // 0..2 external RAM bank bits
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_cart_ready,
  input  logic                       i_cpu_req,
  input  logic                       i_cpu_we,
  input  logic [15:0]                i_cpu_addr,
  input  logic [7:0]                 i_cpu_din,
  output logic                       o_cpu_busy,
  output logic                       o_cpu_ack,
  output logic [7:0]                 o_cpu_dout,
  output logic [14+ROM_BANK_BITS-1:0] o_cart_addr,
  input  logic [7:0]                 i_cart_dout,
  output logic [13+RAM_BANK_BITS-1:0] o_ram_addr,
  output logic                       o_ram_we,
  output logic [7:0]                 o_ram_din,
  input  logic [7:0]                 i_ram_dout
);

  localparam int CA_W = 14 + ROM_BANK_BITS;
  localparam int RA_W = 13 + RAM_BANK_BITS;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ACK} state_t;
  typedef enum logic [1:0] {RG_ROM, RG_RAM, RG_OPEN} region_t;

  state_t            r_state, w_state_nxt;
  region_t           r_region;
  logic [CA_W-1:0]   r_cart_addr;
  logic [RA_W-1:0]   r_ram_addr;
  logic              r_ram_we;
  logic [7:0]        r_ram_din;
  logic [7:0]        r_cpu_dout;

  // MBC1 bank registers
  logic              r_ram_en;
  logic [4:0]        r_rom_bank;
  logic [1:0]        r_bank2;
  logic              r_mode;

  logic              w_accept;
  logic              w_is_rom;
  logic              w_is_ram;
  logic              w_busy;
  logic              w_ack;
  logic [CA_W-1:0]   w_cart_addr;
  logic [RA_W-1:0]   w_ram_addr;

  // Logical 7-bit MBC1 bank for a ROM address; the physical slice is taken
  // later, so oversized bank numbers wrap within the fitted ROM.
  function automatic logic [6:0] f_rom_bank(input logic hi, input logic mode,
                                            input logic [1:0] b2, input logic [4:0] rb);
    if (hi)        return {b2, rb};
    else if (mode) return {b2, 5'd0};
    else           return 7'd0;
  endfunction

  assign w_is_rom    = ~i_cpu_addr[15];
  assign w_is_ram    = (i_cpu_addr[15:13] == 3'b101);
  assign w_accept    = i_cpu_req & i_cart_ready & (r_state == S_IDLE);
  assign w_cart_addr = CA_W'({f_rom_bank(i_cpu_addr[14], r_mode, r_bank2, r_rom_bank),
                              i_cpu_addr[13:0]});

  generate
    if (RAM_BANK_BITS == 0) begin : g_ram_nobank
      assign w_ram_addr = i_cpu_addr[12:0];
    end else begin : g_ram_bank
      // RAM banking only applies in mode 1
      assign w_ram_addr = {(r_mode ? r_bank2[RAM_BANK_BITS-1:0] : {RAM_BANK_BITS{1'b0}}),
                           i_cpu_addr[12:0]};
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; writes skip straight to ACK
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != S_IDLE) | ~i_cart_ready;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = i_cpu_we ? S_ACK : S_ADDR;
      S_ADDR: w_state_nxt = S_DATA;
      S_DATA: w_state_nxt = S_ACK;
      S_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bank register updates from CPU writes into 0x0000-0x7FFF
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ram_en   <= 1'b0;
      r_rom_bank <= 5'd1;
      r_bank2    <= 2'd0;
      r_mode     <= 1'b0;
    end else if (w_accept && i_cpu_we && w_is_rom) begin
      case (i_cpu_addr[14:13])
        2'd0: r_ram_en   <= (i_cpu_din[3:0] == 4'hA);
        2'd1: r_rom_bank <= (i_cpu_din[4:0] == 5'd0) ? 5'd1 : i_cpu_din[4:0];
        2'd2: r_bank2    <= i_cpu_din[1:0];
        default: r_mode  <= i_cpu_din[0];
      endcase
    end
  end

  // Address / data path: latch addresses on accept, capture read data in DATA
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_region    <= RG_OPEN;
      r_cart_addr <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_din   <= 8'd0;
      r_cpu_dout  <= 8'hFF;
    end else begin
      r_ram_we <= 1'b0;
      if (w_accept) begin
        if (!i_cpu_we) begin
          r_cart_addr <= w_cart_addr;
          r_ram_addr  <= w_ram_addr;
          if (w_is_rom)                  r_region <= RG_ROM;
          else if (w_is_ram && r_ram_en) r_region <= RG_RAM;
          else                           r_region <= RG_OPEN;
        end else if (w_is_ram && r_ram_en) begin
          // one-cycle strobe lands in the ACK cycle
          r_ram_addr <= w_ram_addr;
          r_ram_din  <= i_cpu_din;
          r_ram_we   <= 1'b1;
        end
      end
      if (r_state == S_DATA) begin
        case (r_region)
          RG_ROM:  r_cpu_dout <= i_cart_dout;
          RG_RAM:  r_cpu_dout <= i_ram_dout;
          default: r_cpu_dout <= 8'hFF;
        endcase
      end
    end
  end

  assign o_cpu_busy  = w_busy;
  assign o_cpu_ack   = w_ack;
  assign o_cpu_dout  = r_cpu_dout;
  assign o_cart_addr = r_cart_addr;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_we    = r_ram_we;
  assign o_ram_din   = r_ram_din;

endmodule

// File: tb/tb_gb_mbc1.sv
// tb_gb_mbc1: directed and randomized checks of gb_mbc1 against a bank-math
// reference model, with simple registered ROM / RAM memory models attached.
module tb_gb_mbc1;
  localparam int RBB = 2;
  localparam int RAB = 0;

  logic        clk = 1'b0;
  logic        resetn, cart_ready, cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout, cart_dout, ram_din, ram_dout;
  logic        cpu_busy, cpu_ack, ram_we;
  logic [15:0] cart_addr;
  logic [12:0] ram_addr;

  int checks = 0;
  int errors = 0;
  int we_seen = 0;

  always #5 clk = ~clk;

  gb_mbc1 #(.ROM_BANK_BITS(RBB), .RAM_BANK_BITS(RAB)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_cart_ready(cart_ready),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
    .o_cpu_busy(cpu_busy), .o_cpu_ack(cpu_ack), .o_cpu_dout(cpu_dout),
    .o_cart_addr(cart_addr), .i_cart_dout(cart_dout),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
  );

  // ROM contents as a pure function of the physical address (byte[0x4005]=0x5A)
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h1F;
  endfunction

  function automatic logic [7:0] ram_init(input int i);
    return 8'(i * 7) ^ 8'hC3;
  endfunction

  always @(posedge clk) cart_dout <= rom_byte(cart_addr);

  logic [7:0] ram_mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) ram_mem[i] = ram_init(i);
    forever begin
      @(posedge clk);
      ram_dout <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_din;
    end
  end

  always @(negedge clk) if (ram_we === 1'b1) we_seen++;

  // ---------------- reference model ----------------
  int m_ram_en, m_rom_bank, m_bank2, m_mode;
  logic [7:0] ram_ref [0:8191];

  function automatic void m_reset();
    m_ram_en = 0; m_rom_bank = 1; m_bank2 = 0; m_mode = 0;
  endfunction

  function automatic int m_phys(input int a);
    int bank;
    if (a < 'h4000) bank = m_mode ? m_bank2 * 32 : 0;
    else            bank = m_bank2 * 32 + m_rom_bank;
    bank = bank % (1 << RBB);
    return bank * 16384 + (a % 16384);
  endfunction

  function automatic int m_ram_idx(input int a);
    int rb;
    rb = (RAB > 0 && m_mode != 0) ? (m_bank2 % (1 << RAB)) : 0;
    return rb * 8192 + (a % 8192);
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (a < 'h8000) return rom_byte(16'(m_phys(a)));
    if (a >= 'hA000 && a < 'hC000) return (m_ram_en != 0) ? ram_ref[m_ram_idx(a)] : 8'hFF;
    return 8'hFF;
  endfunction

  function automatic void m_write(input int a, input int d);
    if (a < 'h2000)      m_ram_en = ((d % 16) == 10) ? 1 : 0;
    else if (a < 'h4000) begin m_rom_bank = d % 32; if (m_rom_bank == 0) m_rom_bank = 1; end
    else if (a < 'h6000) m_bank2 = d % 4;
    else if (a < 'h8000) m_mode = d % 2;
    else if (a >= 'hA000 && a < 'hC000 && m_ram_en != 0) ram_ref[m_ram_idx(a)] = 8'(d);
  endfunction

  // ---------------- bus drivers (observe only, no checking) ----------------
  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output int ack_cyc,
                          output int acks, output logic [15:0] ca, output logic [12:0] ra,
                          output bit stable);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(posedge clk); #1 cpu_req = 1'b0;
    ack_cyc = -1; acks = 0; stable = 1'b1; d = 8'hxx; ca = 'x; ra = 'x;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) begin ca = cart_addr; ra = ram_addr; end
      else if (n <= 3 && (cart_addr !== ca || ram_addr !== ra)) stable = 1'b0;
      if (cpu_ack === 1'b1) begin
        acks++;
        if (ack_cyc < 0) begin ack_cyc = n; d = cpu_dout; end
      end
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] dv, output int ack_cyc,
                           output int acks, output int we_cnt, output int we_cyc,
                           output logic [12:0] ra, output logic [7:0] rdin);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = dv;
    @(posedge clk); #1 cpu_req = 1'b0;
    ack_cyc = -1; acks = 0; we_cnt = 0; we_cyc = -1; ra = 'x; rdin = 'x;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin acks++; if (ack_cyc < 0) ack_cyc = n; end
      if (ram_we === 1'b1) begin
        we_cnt++;
        if (we_cyc < 0) begin we_cyc = n; ra = ram_addr; rdin = ram_din; end
      end
    end
    m_write(int'(a), int'(dv));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b1; cart_ready = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0; cpu_din = 8'h0;
    #3 resetn = 1'b0;
    #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", cpu_ack); end
    checks++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL reset_dout got %h want ff", cpu_dout); end
    checks++; if (cart_addr !== 16'h0 || ram_addr !== 13'h0) begin errors++;
      $display("FAIL reset_addr got cart=%h ram=%h want 0/0", cart_addr, ram_addr); end
    checks++; if (ram_we !== 1'b0 || ram_din !== 8'h0) begin errors++;
      $display("FAIL reset_ram got we=%b din=%h want 0/00", ram_we, ram_din); end
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_notready got %b want 1", cpu_busy); end
    m_reset();
    for (int i = 0; i < 8192; i++) ram_ref[i] = ram_init(i);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); cart_ready = 1'b1; #1;
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL ready_busy got %b want 0", cpu_busy); end
  endtask

  task automatic test_basic_read();
    logic [7:0] d; int ac, n; logic [15:0] ca; logic [12:0] ra; bit st;
    bus_read(16'h4005, d, ac, n, ca, ra, st);
    checks++; if (ca !== 16'h4005 || !st) begin errors++;
      $display("FAIL basic_cart_addr got %h stable=%0d want 4005 stable=1", ca, st); end
    checks++; if (ac != 3 || n != 1) begin errors++;
      $display("FAIL basic_ack got cycle=%0d count=%0d want 3/1", ac, n); end
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL basic_dout got %h want 5a", d); end
  endtask

  task automatic test_rom_bank();
    logic [7:0] d, rd; int ac, n, wc, wy; logic [15:0] ca; logic [12:0] ra; bit st;
    bus_write(16'h2000, 8'h00, ac, n, wc, wy, ra, rd);
    checks++; if (ac != 1 || n != 1 || wc != 0) begin errors++;
      $display("FAIL regwr_ack got cycle=%0d count=%0d we=%0d want 1/1/0", ac, n, wc); end
    bus_read(16'h4000, d, ac, n, ca, ra, st);
    checks++; if (ca !== 16'h4000) begin errors++; $display("FAIL bank0_as_1 got %h want 4000", ca); end
    bus_write(16'h2000, 8'h03, ac, n, wc, wy, ra, rd);
    bus_read(16'h7FFF, d, ac, n, ca, ra, st);
    checks++; if (ca !== 16'hFFFF || d !== rom_byte(16'hFFFF)) begin errors++;
      $display("FAIL bank3_top got %h/%h want ffff/%h", ca, d, rom_byte(16'hFFFF)); end
    bus_write(16'h2000, 8'h21, ac, n, wc, wy, ra, rd);
    bus_read(16'h4000, d, ac, n, ca, ra, st);
    checks++; if (ca !== 16'h4000) begin errors++; $display("FAIL bank_5bit got %h want 4000", ca); end
    bus_write(16'h2000, 8'h02, ac, n, wc, wy, ra, rd);
    bus_read(16'h4010, d, ac, n, ca, ra, st);
    checks++; if (ca !== 16'h8010) begin errors++; $display("FAIL bank2_read got %h want 8010", ca); end
    bus_write(16'h2000, 8'h01, ac, n, wc, wy, ra, rd);
  endtask

  task automatic test_ram();
    logic [7:0] d, rd; int ac, n, wc, wy, w0; logic [15:0] ca; logic [12:0] ra; bit st;
    w0 = we_seen;
    bus_read(16'hA000, d, ac, n, ca, ra, st);
    checks++; if (d !== 8'hFF || we_seen != w0 || ac != 3) begin errors++;
      $display("FAIL ram_dis_read got %h we=%0d ack=%0d want ff/0/3", d, we_seen - w0, ac); end
    bus_write(16'h0000, 8'h0A, ac, n, wc, wy, ra, rd);
    bus_write(16'hA123, 8'h77, ac, n, wc, wy, ra, rd);
    checks++; if (wc != 1 || wy != 1 || ra !== 13'h0123 || rd !== 8'h77) begin errors++;
      $display("FAIL ram_write got cnt=%0d cyc=%0d addr=%h din=%h want 1/1/0123/77", wc, wy, ra, rd); end
    checks++; if (ac != 1) begin errors++; $display("FAIL ram_write_ack got %0d want 1", ac); end
    bus_read(16'hA123, d, ac, n, ca, ra, st);
    checks++; if (d !== 8'h77 || ra !== 13'h0123) begin errors++;
      $display("FAIL ram_readback got %h @%h want 77 @0123", d, ra); end
    bus_write(16'h0000, 8'h0B, ac, n, wc, wy, ra, rd);
    bus_write(16'hA123, 8'h11, ac, n, wc, wy, ra, rd);
    checks++; if (wc != 0) begin errors++; $display("FAIL ram_dis_write got we=%0d want 0", wc); end
    bus_read(16'hA123, d, ac, n, ca, ra, st);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ram_dis_read2 got %h want ff", d); end
    bus_write(16'h1FFF, 8'h5A, ac, n, wc, wy, ra, rd);
    bus_read(16'hA123, d, ac, n, ca, ra, st);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL ram_drop_kept got %h want 77", d); end
  endtask

  task automatic test_unmapped();
    logic [7:0] d, rd; int ac, n, wc, wy; logic [15:0] ca; logic [12:0] ra; bit st;
    logic [15:0] addrs [4];
    addrs = '{16'h8000, 16'h9FFF, 16'hC000, 16'hFFFF};
    foreach (addrs[i]) begin
      bus_read(addrs[i], d, ac, n, ca, ra, st);
      checks++; if (d !== 8'hFF || ac != 3 || n != 1) begin errors++;
        $display("FAIL unmapped_read %h got %h ack=%0d/%0d want ff 3/1", addrs[i], d, ac, n); end
    end
    bus_write(16'hC000, 8'h0A, ac, n, wc, wy, ra, rd);
    checks++; if (ac != 1 || wc != 0) begin errors++;
      $display("FAIL unmapped_write got ack=%0d we=%0d want 1/0", ac, wc); end
  endtask

  task automatic test_busy();
    int acks, ac; bit busy_ok; logic [7:0] d;
    cart_ready = 1'b0;
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
    @(negedge clk); cpu_req = 1'b0;
    busy_ok = (cpu_busy === 1'b1);
    acks = 0;
    repeat (5) begin @(negedge clk); if (cpu_ack === 1'b1) acks++; end
    checks++; if (!busy_ok || acks != 0) begin errors++;
      $display("FAIL notready_hold got busy_ok=%0d acks=%0d want 1/0", busy_ok, acks); end
    cart_ready = 1'b1;
    @(negedge clk); cpu_req = 1'b1; cpu_addr = 16'h4001;
    @(posedge clk); #1 cpu_addr = 16'h4002;
    acks = 0; ac = -1; d = 8'hxx;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) busy_ok = (cpu_busy === 1'b1);
      if (n == 2) cpu_req = 1'b0;
      if (cpu_ack === 1'b1) begin acks++; if (ac < 0) begin ac = n; d = cpu_dout; end end
    end
    checks++; if (acks != 1 || ac != 3 || !busy_ok) begin errors++;
      $display("FAIL req_in_addr got acks=%0d cyc=%0d busy_ok=%0d want 1/3/1", acks, ac, busy_ok); end
    checks++; if (d !== m_read('h4001)) begin errors++;
      $display("FAIL req_in_addr_data got %h want %h", d, m_read('h4001)); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, rd; int ac, n, wc, wy, w0, acks; logic [15:0] ca; logic [12:0] ra; bit st;
    bus_write(16'h2000, 8'h03, ac, n, wc, wy, ra, rd);
    bus_write(16'h0000, 8'h0A, ac, n, wc, wy, ra, rd);
    bus_write(16'h6000, 8'h01, ac, n, wc, wy, ra, rd);
    w0 = we_seen; acks = 0;
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk); resetn = 1'b0;
    #1 if (cpu_ack === 1'b1) acks++;
    @(negedge clk); resetn = 1'b1;
    m_reset();
    repeat (5) begin @(negedge clk); if (cpu_ack === 1'b1) acks++; end
    checks++; if (acks != 0 || we_seen != w0) begin errors++;
      $display("FAIL reset_abort got acks=%0d we=%0d want 0/0", acks, we_seen - w0); end
    checks++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL reset_abort_dout got %h want ff", cpu_dout); end
    bus_read(16'h4000, d, ac, n, ca, ra, st);
    checks++; if (ca !== 16'h4000) begin errors++; $display("FAIL reset_rom_bank got %h want 4000", ca); end
    bus_read(16'hA123, d, ac, n, ca, ra, st);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL reset_ram_en got %h want ff", d); end
  endtask

  task automatic test_random();
    logic [7:0] d, rd, dv, exp_d; int ac, n, wc, wy, op, a, exp_we, exp_ra;
    logic [15:0] ca; logic [12:0] ra; bit st;
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 5);
      dv = 8'($urandom);
      case (op)
        0: begin
          a = $urandom_range(0, 'h7FFF);
          if ($urandom_range(0, 2) == 0) begin a = $urandom_range(0, 'h1FFF); dv[3:0] = 4'hA; end
          bus_write(16'(a), dv, ac, n, wc, wy, ra, rd);
          checks++; if (ac != 1 || wc != 0) begin errors++;
            $display("FAIL rnd_regwr %h got ack=%0d we=%0d want 1/0", a, ac, wc); end
        end
        1, 2: begin
          a = $urandom_range(0, 'h7FFF);
          exp_d = m_read(a);
          bus_read(16'(a), d, ac, n, ca, ra, st);
          checks++; if (ca !== 16'(m_phys(a)) || !st || d !== exp_d || ac != 3) begin errors++;
            $display("FAIL rnd_rom %h got ca=%h d=%h ack=%0d st=%0d want %h/%h/3/1",
                     a, ca, d, ac, st, 16'(m_phys(a)), exp_d); end
        end
        3: begin
          a = 'hA000 + $urandom_range(0, 'h3F) + ($urandom_range(0, 1) * 'h1FC0);
          exp_we = m_ram_en; exp_ra = m_ram_idx(a);
          bus_write(16'(a), dv, ac, n, wc, wy, ra, rd);
          checks++; if (ac != 1 || wc != exp_we ||
                        (exp_we != 0 && (ra !== 13'(exp_ra) || rd !== dv || wy != 1))) begin errors++;
            $display("FAIL rnd_ramwr %h got we=%0d ra=%h din=%h want %0d/%h/%h", a, wc, ra, rd,
                     exp_we, 13'(exp_ra), dv); end
        end
        4: begin
          a = 'hA000 + $urandom_range(0, 'h3F) + ($urandom_range(0, 1) * 'h1FC0);
          exp_d = m_read(a);
          bus_read(16'(a), d, ac, n, ca, ra, st);
          checks++; if (d !== exp_d || ac != 3) begin errors++;
            $display("FAIL rnd_ramrd %h got %h ack=%0d want %h/3", a, d, ac, exp_d); end
        end
        default: begin
          a = ($urandom_range(0, 1) != 0) ? $urandom_range('h8000, 'h9FFF) : $urandom_range('hC000, 'hFFFF);
          if ($urandom_range(0, 1) != 0) begin
            bus_write(16'(a), dv, ac, n, wc, wy, ra, rd);
            checks++; if (ac != 1 || wc != 0) begin errors++;
              $display("FAIL rnd_openwr %h got ack=%0d we=%0d want 1/0", a, ac, wc); end
          end else begin
            bus_read(16'(a), d, ac, n, ca, ra, st);
            checks++; if (d !== 8'hFF || ac != 3) begin errors++;
              $display("FAIL rnd_openrd %h got %h ack=%0d want ff/3", a, d, ac); end
          end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_rom_bank();
    test_ram();
    test_unmapped();
    test_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
